led_pwm_axil_regs: RTL and testbench

// AXI4-Lite slave end of the led_pwm control path: answers the master VIP / PS GP port, holds 4 32-bit

---
 rtl/led_pwm_axil_regs_if.sv | 42 ++++
 rtl/led_pwm_axil_regs.sv | 195 +++++++++++++++++++
 tb/tb_led_pwm_axil_regs.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_pwm_axil_regs_if.sv
// AXI4-Lite bus bundle for the led_pwm register block.
// slave modport  : the register block (accepts AW/W/AR, returns B/R).
// master modport : the bus driver (interconnect, PS GP port, or a bench).
// Signals: AW (AWADDR, AWPROT, AWVALID, AWREADY), W (WDATA, WSTRB, WVALID, WREADY),
//          B (BRESP, BVALID, BREADY), AR (ARADDR, ARPROT, ARVALID, ARREADY),
//          R (RDATA, RRESP, RVALID, RREADY).
interface led_pwm_axil_regs_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]                      AWPROT;
  logic                            AWVALID;
  logic                            AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB;
  logic                            WVALID;
  logic                            WREADY;
  logic [1:0]                      BRESP;
  logic                            BVALID;
  logic                            BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]                      ARPROT;
  logic                            ARVALID;
  logic                            ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA;
  logic [1:0]                      RRESP;
  logic                            RVALID;
  logic                            RREADY;

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/led_pwm_axil_regs.sv
// AXI4-Lite slave holding CTRL/DUTY_R/DUTY_G/DUTY_B and driving a 3-channel RGB PWM.
// Ports:
//   ACLK     in   clock, rising edge
//   ARESETN  in   asynchronous active-low reset
//   s_axi    slave modport of led_pwm_axil_regs_if (AW/W/B/AR/R channels)
//   led_rgb  out  {B,G,R} PWM outputs, active high, registered
// Register map: 0x0 CTRL (bit0 enable, [31:16] prescale), 0x4/0x8/0xC duty R/G/B.
//
// state  | meaning
// W_IDLE | collecting AW and W (either order); write fires once both are in hand
// W_RESP | register written, BVALID up, waiting for BREADY
// R_IDLE | ARREADY up, waiting for a read address
// R_DATA | RDATA/RVALID held until RREADY
module led_pwm_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int PWM_WIDTH          = 8
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  led_pwm_axil_regs_if.slave s_axi,
  output logic [2:0]         led_rgb
);
  localparam int NBYTES = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];

  // Keeps every READY low during reset and for the first cycle after release.
  logic bus_en;

  logic                          aw_held, w_held;
  logic [C_S_AXI_ADDR_WIDTH-3:0] aw_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data;
  logic [NBYTES-1:0]             w_strb;

  logic aw_ready, w_ready, b_valid, ar_ready, r_valid;
  logic aw_hs, w_hs, ar_hs, do_write;
  logic [C_S_AXI_ADDR_WIDTH-3:0] wr_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
  logic [NBYTES-1:0]             wr_strb;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata;

  wire unused_bits = ^{s_axi.AWPROT, s_axi.ARPROT, s_axi.AWADDR[1:0], s_axi.ARADDR[1:0]};

  assign aw_hs = s_axi.AWVALID & aw_ready;
  assign w_hs  = s_axi.WVALID & w_ready;
  assign ar_hs = s_axi.ARVALID & ar_ready;

  // A channel arriving this cycle is used directly so the write lands on its handshake edge.
  assign wr_idx  = aw_held ? aw_idx : s_axi.AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_data = w_held ? w_data : s_axi.WDATA;
  assign wr_strb = w_held ? w_strb : s_axi.WSTRB;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    aw_ready    = 1'b0;
    w_ready     = 1'b0;
    b_valid     = 1'b0;
    do_write    = 1'b0;
    case (w_state)
      W_IDLE: begin
        aw_ready = bus_en & ~aw_held;
        w_ready  = bus_en & ~w_held;
        if ((aw_held | aw_hs) & (w_held | w_hs)) begin
          do_write    = 1'b1;
          w_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (s_axi.BREADY) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_nxt = r_state;
    ar_ready    = 1'b0;
    r_valid     = 1'b0;
    case (r_state)
      R_IDLE: begin
        ar_ready = bus_en;
        if (ar_hs) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        r_valid = 1'b1;
        if (s_axi.RREADY) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  assign s_axi.AWREADY = aw_ready;
  assign s_axi.WREADY  = w_ready;
  assign s_axi.BVALID  = b_valid;
  assign s_axi.BRESP   = 2'b00;
  assign s_axi.ARREADY = ar_ready;
  assign s_axi.RVALID  = r_valid;
  assign s_axi.RDATA   = rdata;
  assign s_axi.RRESP   = 2'b00;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      bus_en  <= 1'b0;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_idx  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      rdata   <= '0;
    end else begin
      bus_en <= 1'b1;
      if (do_write) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_held <= 1'b1;
          aw_idx  <= s_axi.AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
          w_held <= 1'b1;
          w_data <= s_axi.WDATA;
          w_strb <= s_axi.WSTRB;
        end
      end
      // regs is sampled before this edge's write commits, so a coincident read sees the old value.
      if (ar_hs) rdata <= regs[s_axi.ARADDR[C_S_AXI_ADDR_WIDTH-1:2]];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (do_write) begin
      for (int b = 0; b < NBYTES; b++)
        if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  logic                 pwm_en;
  logic [15:0]          prescale, pre_cnt;
  logic                 tick, wrap;
  logic [PWM_WIDTH-1:0] cnt, duty_r, duty_g, duty_b;

  assign pwm_en   = regs[0][0];
  assign prescale = regs[0][31:16];
  assign tick     = (pre_cnt == prescale);
  assign wrap     = tick & (cnt == {PWM_WIDTH{1'b1}});

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pre_cnt <= '0;
      cnt     <= '0;
      duty_r  <= '0;
      duty_g  <= '0;
      duty_b  <= '0;
      led_rgb <= '0;
    end else if (!pwm_en) begin
      pre_cnt <= '0;
      cnt     <= '0;
      duty_r  <= regs[1][PWM_WIDTH-1:0];
      duty_g  <= regs[2][PWM_WIDTH-1:0];
      duty_b  <= regs[3][PWM_WIDTH-1:0];
      led_rgb <= '0;
    end else begin
      // ">=" rather than "==" so a prescale lowered below the running count recovers next cycle.
      pre_cnt <= (pre_cnt >= prescale) ? '0 : pre_cnt + 1'b1;
      if (tick) cnt <= cnt + 1'b1;
      if (wrap) begin
        duty_r <= regs[1][PWM_WIDTH-1:0];
        duty_g <= regs[2][PWM_WIDTH-1:0];
        duty_b <= regs[3][PWM_WIDTH-1:0];
      end
      led_rgb <= {cnt < duty_b, cnt < duty_g, cnt < duty_r};
    end
  end
endmodule

// File: tb/tb_led_pwm_axil_regs.sv
// Self-checking bench for led_pwm_axil_regs: directed register/PWM scenarios plus
// randomized AXI-Lite traffic checked against a behavioural model of the register map and PWM.
module tb_led_pwm_axil_regs;
  logic       ACLK = 1'b0;
  logic       ARESETN = 1'b0;
  logic [2:0] led_rgb;

  led_pwm_axil_regs_if bus ();

  led_pwm_axil_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .PWM_WIDTH(8)
  ) dut (
    .ACLK(ACLK),
    .ARESETN(ARESETN),
    .s_axi(bus),
    .led_rgb(led_rgb)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_pass = 0;
  int writes_issued = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: register map written per byte strobe when both AW and W have been seen,
  // PWM as integer counters: count advances once every P+1 enabled cycles, modulo 256.
  logic [31:0] m_regs [4];
  int          m_pre, m_cnt, m_p;
  int          m_sh [3];
  logic [2:0]  m_led;
  bit          m_aw_seen, m_w_seen;
  int          m_aw_idx;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] rd_q [$];
  logic [31:0] exp_rd;
  int          m_bcount = 0;

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) m_regs[i] = '0;
      for (int i = 0; i < 3; i++) m_sh[i] = 0;
      m_pre = 0; m_cnt = 0; m_led = '0;
      m_aw_seen = 0; m_w_seen = 0;
      rd_q.delete();
    end else begin
      m_p = int'(m_regs[0][31:16]);
      if (!m_regs[0][0]) begin
        m_pre = 0; m_cnt = 0; m_led = '0;
        for (int i = 0; i < 3; i++) m_sh[i] = int'(m_regs[i+1][7:0]);
      end else begin
        for (int i = 0; i < 3; i++) m_led[i] = (m_cnt < m_sh[i]);
        if (m_pre == m_p) begin
          m_pre = 0;
          m_cnt = (m_cnt + 1) % 256;
          if (m_cnt == 0)
            for (int i = 0; i < 3; i++) m_sh[i] = int'(m_regs[i+1][7:0]);
        end else if (m_pre > m_p) m_pre = 0;
        else m_pre = m_pre + 1;
      end

      if (bus.RVALID && bus.RREADY) begin
        chk("rresp", 32'(bus.RRESP), 32'd0);
        if (rd_q.size() == 0) chk("rdata_unexpected", 32'd1, 32'd0);
        else begin
          exp_rd = rd_q.pop_front();
          chk("rdata_model", bus.RDATA, exp_rd);
        end
      end
      if (bus.ARVALID && bus.ARREADY) rd_q.push_back(m_regs[bus.ARADDR[3:2]]);
      if (bus.BVALID && bus.BREADY) begin
        chk("bresp", 32'(bus.BRESP), 32'd0);
        m_bcount++;
      end
      if (bus.AWVALID && bus.AWREADY) begin
        m_aw_seen = 1; m_aw_idx = int'(bus.AWADDR[3:2]);
      end
      if (bus.WVALID && bus.WREADY) begin
        m_w_seen = 1; m_wdata = bus.WDATA; m_wstrb = bus.WSTRB;
      end
      if (m_aw_seen && m_w_seen) begin
        for (int b = 0; b < 4; b++)
          if (m_wstrb[b]) m_regs[m_aw_idx][8*b +: 8] = m_wdata[8*b +: 8];
        m_aw_seen = 0; m_w_seen = 0;
      end
    end
  end

  always @(negedge ACLK) chk("led_rgb", 32'(led_rgb), 32'(m_led));

  task automatic send_aw(input logic [3:0] a, input int dly, output bit ok);
    repeat (dly) @(negedge ACLK);
    bus.AWADDR = a; bus.AWVALID = 1'b1; ok = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.AWREADY) begin ok = 1; break; end
      @(negedge ACLK);
    end
    if (ok) @(posedge ACLK);
    @(negedge ACLK);
    bus.AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly, output bit ok);
    repeat (dly) @(negedge ACLK);
    bus.WDATA = d; bus.WSTRB = s; bus.WVALID = 1'b1; ok = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.WREADY) begin ok = 1; break; end
      @(negedge ACLK);
    end
    if (ok) @(posedge ACLK);
    @(negedge ACLK);
    bus.WVALID = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] a, input int dly, output bit ok);
    repeat (dly) @(negedge ACLK);
    bus.ARADDR = a; bus.ARVALID = 1'b1; ok = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.ARREADY) begin ok = 1; break; end
      @(negedge ACLK);
    end
    if (ok) @(posedge ACLK);
    @(negedge ACLK);
    bus.ARVALID = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_d, input int w_d, input int b_d);
    bit ok_a, ok_w, ok_b;
    fork
      send_aw(a, aw_d, ok_a);
      send_w(d, s, w_d, ok_w);
    join
    chk("aw_accepted", 32'(ok_a), 32'd1);
    chk("w_accepted", 32'(ok_w), 32'd1);
    #1;
    chk("bvalid_after_handshake", 32'(bus.BVALID), 32'd1);
    for (int k = 0; k < b_d; k++) begin
      chk("bvalid_held", 32'(bus.BVALID), 32'd1);
      chk("awready_low_in_resp", 32'(bus.AWREADY), 32'd0);
      chk("wready_low_in_resp", 32'(bus.WREADY), 32'd0);
      @(negedge ACLK); #1;
    end
    bus.BREADY = 1'b1; ok_b = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.BVALID) begin ok_b = 1; break; end
      @(negedge ACLK); #1;
    end
    chk("b_handshake", 32'(ok_b), 32'd1);
    if (ok_b) @(posedge ACLK);
    @(negedge ACLK);
    bus.BREADY = 1'b0;
    #1;
    chk("bvalid_single", 32'(bus.BVALID), 32'd0);
    writes_issued++;
  endtask

  task automatic axi_read(input logic [3:0] a, input int ar_d, input int r_d, output logic [31:0] d);
    bit ok_ar;
    logic [31:0] first;
    send_ar(a, ar_d, ok_ar);
    chk("ar_accepted", 32'(ok_ar), 32'd1);
    #1;
    chk("rvalid_latency", 32'(bus.RVALID), 32'd1);
    first = bus.RDATA;
    for (int k = 0; k < r_d; k++) begin
      chk("rvalid_held", 32'(bus.RVALID), 32'd1);
      chk("rdata_stable", bus.RDATA, first);
      chk("arready_low_in_data", 32'(bus.ARREADY), 32'd0);
      @(negedge ACLK); #1;
    end
    bus.RREADY = 1'b1;
    if (bus.RVALID) @(posedge ACLK);
    @(negedge ACLK);
    bus.RREADY = 1'b0;
    #1;
    chk("rvalid_drop", 32'(bus.RVALID), 32'd0);
    d = first;
  endtask

  task automatic count_led(input int n, output int cr, output int cg, output int cb);
    cr = 0; cg = 0; cb = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge ACLK); #1;
      cr += int'(led_rgb[0]); cg += int'(led_rgb[1]); cb += int'(led_rgb[2]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int cr, cg, cb, b_before, wr_before;
    bit ok;
    bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 0; bus.BREADY = 0;
    bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 0; bus.RREADY = 0;

    repeat (3) @(negedge ACLK);
    #1;
    chk("rst_awready", 32'(bus.AWREADY), 32'd0);
    chk("rst_wready", 32'(bus.WREADY), 32'd0);
    chk("rst_arready", 32'(bus.ARREADY), 32'd0);
    chk("rst_bvalid", 32'(bus.BVALID), 32'd0);
    chk("rst_rvalid", 32'(bus.RVALID), 32'd0);
    chk("rst_rdata", bus.RDATA, 32'd0);
    chk("rst_led", 32'(led_rgb), 32'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (3) @(negedge ACLK);

    for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), 0, 0, d);
      chk("readback_basic", d, 32'(i + 1));
    end

    axi_write(4'h8, 32'h0000_0033, 4'hF, 3, 0, 0);
    axi_read(4'h8, 0, 0, d);
    chk("readback_w_before_aw", d, 32'h0000_0033);

    axi_write(4'h4, 32'h0000_0055, 4'hF, 0, 0, 5);
    axi_read(4'h5, 0, 5, d);
    chk("readback_slow_ready", d, 32'h0000_0055);

    axi_write(4'h4, 32'hFFFF_FFFF, 4'hF, 0, 1, 0);
    axi_write(4'h4, 32'h0000_0000, 4'b0010, 1, 0, 0);
    axi_read(4'h4, 0, 0, d);
    chk("readback_strobe", d, 32'hFFFF_00FF);

    axi_write(4'h8, 32'd0, 4'hF, 0, 0, 0);
    axi_write(4'hC, 32'd0, 4'hF, 0, 0, 0);
    axi_write(4'h4, 32'd64, 4'hF, 0, 0, 0);
    axi_write(4'h0, 32'h0000_0001, 4'hF, 0, 0, 0);
    repeat (300) @(negedge ACLK);
    count_led(256, cr, cg, cb);
    chk("pwm_r_64_of_256", 32'(cr), 32'd64);
    chk("pwm_g_off", 32'(cg), 32'd0);
    chk("pwm_b_off", 32'(cb), 32'd0);

    axi_write(4'h0, 32'h0003_0001, 4'hF, 0, 0, 0);
    repeat (500) @(negedge ACLK);
    axi_write(4'h8, 32'd128, 4'hF, 0, 0, 0);
    repeat (2100) @(negedge ACLK);
    count_led(1024, cr, cg, cb);
    chk("pwm_r_prescaled", 32'(cr), 32'd256);
    chk("pwm_g_half", 32'(cg), 32'd512);
    chk("pwm_b_off_prescaled", 32'(cb), 32'd0);

    send_aw(4'h4, 0, ok);
    chk("aw_before_reset", 32'(ok), 32'd1);
    ARESETN = 1'b0;
    #1;
    chk("midrst_led", 32'(led_rgb), 32'd0);
    chk("midrst_awready", 32'(bus.AWREADY), 32'd0);
    chk("midrst_wready", 32'(bus.WREADY), 32'd0);
    chk("midrst_bvalid", 32'(bus.BVALID), 32'd0);
    chk("midrst_rvalid", 32'(bus.RVALID), 32'd0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (3) @(negedge ACLK);
    #1;
    chk("no_b_after_reset", 32'(bus.BVALID), 32'd0);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), 0, 0, d);
      chk("readback_after_reset", d, 32'd0);
    end

    b_before = m_bcount;
    wr_before = writes_issued;
    for (int n = 0; n < 150; n++) begin
      int op;
      logic [3:0] a, ra;
      logic [31:0] wd;
      op = int'($urandom_range(0, 2));
      a  = 4'($urandom_range(0, 15));
      ra = 4'($urandom_range(0, 15));
      wd = $urandom;
      if (a[3:2] == 2'd0) wd = {16'($urandom_range(0, 3)), 15'($urandom), 1'($urandom)};
      if (op == 0)
        axi_write(a, wd, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      else if (op == 1)
        axi_read(ra, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), d);
      else
        fork
          axi_write(a, wd, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
          axi_read(ra, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), d);
        join
      repeat (int'($urandom_range(0, 20))) @(negedge ACLK);
    end
    repeat (5) @(negedge ACLK);
    chk("one_b_per_write", 32'(m_bcount - b_before), 32'(writes_issued - wr_before));
    chk("read_queue_drained", 32'(rd_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
